// File: rtl/spi_regfile_arbiter_pkg.sv
// rtl/spi_regfile_arbiter_pkg.sv - shared types for the SPI/host register-file arbiter
package spi_regfile_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  typedef enum logic {
    SEL_SPI  = 1'b0,
    SEL_HOST = 1'b1
  } sel_t;

endpackage

// File: rtl/spi_pending_buf.sv
// rtl/spi_pending_buf.sv - one-deep capture buffer for SPI strobes with sticky overflow
module spi_pending_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic             op_wr,
  output logic [WIDTH-1:0] buf_addr,
  output logic [WIDTH-1:0] buf_data,
  output logic             ovf
);

  logic strobe;
  logic room;

  assign strobe = wr_en | rd_en;
  // A pop in the same cycle frees the slot, so the incoming strobe still fits.
  assign room   = !valid || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      op_wr    <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      ovf      <= 1'b0;
    end else begin
      if (strobe && room) begin
        valid    <= 1'b1;
        op_wr    <= wr_en;
        buf_addr <= addr;
        buf_data <= wdata;
      end else if (pop) begin
        valid <= 1'b0;
      end
      // Simultaneous strobes keep the write and lose the read.
      if ((strobe && !room) || (wr_en && rd_en)) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_regfile_arbiter.sv
// rtl/spi_regfile_arbiter.sv - shares a single-port register file between SPI and a host
module spi_regfile_arbiter
  import spi_regfile_arbiter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SPI_Wr_EN,
  input  logic             SPI_Rd_EN,
  input  logic [WIDTH-1:0] SPI_Address,
  input  logic [WIDTH-1:0] SPI_Wr_Data,
  output logic [WIDTH-1:0] SPI_Rd_Data,
  output logic             SPI_Rd_Valid,
  output logic             SPI_Ovf,
  input  logic             H_Req,
  input  logic             H_Wr,
  input  logic [WIDTH-1:0] H_Address,
  input  logic [WIDTH-1:0] H_Wr_Data,
  output logic             H_Ack,
  output logic [WIDTH-1:0] H_Rd_Data,
  output logic             RF_Wr_EN,
  output logic             RF_Rd_EN,
  output logic [WIDTH-1:0] RF_Address,
  output logic [WIDTH-1:0] RF_Wr_Data,
  input  logic [WIDTH-1:0] RF_Rd_Data
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t           state;
  sel_t             cur_sel;
  logic             cur_wr;
  logic             h_req_q;
  logic [CNT_W-1:0] starve_cnt;

  logic             pend_valid;
  logic             pend_wr;
  logic [WIDTH-1:0] pend_addr;
  logic [WIDTH-1:0] pend_data;

  logic starved;
  logic grant_spi;
  logic grant_host;

  spi_pending_buf #(.WIDTH(WIDTH)) u_pending (
    .clk      (CLK),
    .rst_n    (RST),
    .wr_en    (SPI_Wr_EN),
    .rd_en    (SPI_Rd_EN),
    .addr     (SPI_Address),
    .wdata    (SPI_Wr_Data),
    .pop      (grant_spi),
    .valid    (pend_valid),
    .op_wr    (pend_wr),
    .buf_addr (pend_addr),
    .buf_data (pend_data),
    .ovf      (SPI_Ovf)
  );

  assign starved    = h_req_q && (starve_cnt == CNT_MAX);
  assign grant_spi  = (state == ST_IDLE) && pend_valid && !starved;
  assign grant_host = (state == ST_IDLE) && h_req_q && !grant_spi;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= ST_IDLE;
      cur_sel      <= SEL_SPI;
      cur_wr       <= 1'b0;
      h_req_q      <= 1'b0;
      starve_cnt   <= '0;
      RF_Wr_EN     <= 1'b0;
      RF_Rd_EN     <= 1'b0;
      RF_Address   <= '0;
      RF_Wr_Data   <= '0;
      SPI_Rd_Data  <= '0;
      SPI_Rd_Valid <= 1'b0;
      H_Ack        <= 1'b0;
      H_Rd_Data    <= '0;
    end else begin
      RF_Wr_EN     <= 1'b0;
      RF_Rd_EN     <= 1'b0;
      SPI_Rd_Valid <= 1'b0;
      H_Ack        <= 1'b0;
      // The request level is ignored across the ack edge so a host that drops late is not re-served.
      h_req_q      <= H_Req && !H_Ack;

      if (!h_req_q || grant_host) begin
        starve_cnt <= '0;
      end else if (grant_spi && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (grant_spi) begin
            cur_sel    <= SEL_SPI;
            cur_wr     <= pend_wr;
            RF_Address <= pend_addr;
            if (pend_wr) RF_Wr_Data <= pend_data;
            RF_Wr_EN   <= pend_wr;
            RF_Rd_EN   <= !pend_wr;
            state      <= ST_ISSUE;
          end else if (grant_host) begin
            cur_sel    <= SEL_HOST;
            cur_wr     <= H_Wr;
            RF_Address <= H_Address;
            if (H_Wr) RF_Wr_Data <= H_Wr_Data;
            RF_Wr_EN   <= H_Wr;
            RF_Rd_EN   <= !H_Wr;
            H_Ack      <= H_Wr;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= cur_wr ? ST_IDLE : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (cur_sel == SEL_SPI) begin
            SPI_Rd_Data  <= RF_Rd_Data;
            SPI_Rd_Valid <= 1'b1;
          end else begin
            H_Rd_Data <= RF_Rd_Data;
            H_Ack     <= 1'b1;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_regfile_arbiter.md
# spi_regfile_arbiter

Shares one single-port register file between the SPI slave datapath (write/read strobes, address, write data) and a local host requester. SPI accesses have priority, and a starvation guard reserves slots for the host. SPI strobes are captured into a one-deep pending buffer. Each access is sequenced onto the register file, and read data is returned to the requester that issued it. The block sits between the SPI slave top and the register file, in the same clock domain.

## Interface
- WIDTH, 8, address and data bus width
- STARVE_MAX, 4, consecutive SPI grants allowed while host waits before one host slot is forced
- CLK  in  1  system clock; SPI slave strobes are synchronous to it
- RST  in  1  asynchronous, active-low reset
- SPI_Wr_EN  in  1  single-cycle SPI write strobe
- SPI_Rd_EN  in  1  single-cycle SPI read strobe
- SPI_Address  in  WIDTH  SPI access address, valid with strobe
- SPI_Wr_Data  in  WIDTH  SPI write data, valid with SPI_Wr_EN
- SPI_Rd_Data  out  WIDTH  read data returned to SPI slave
- SPI_Rd_Valid  out  1  one-cycle pulse, SPI_Rd_Data valid
- SPI_Ovf  out  1  sticky: an SPI strobe arrived while pending buffer full
- H_Req  in  1  host request, held until H_Ack
- H_Wr  in  1  1 = write, 0 = read; stable while H_Req
- H_Address  in  WIDTH  host address; stable while H_Req
- H_Wr_Data  in  WIDTH  host write data; stable while H_Req
- H_Ack  out  1  one-cycle pulse: write done / read data valid
- H_Rd_Data  out  WIDTH  host read data, valid with H_Ack
- RF_Wr_EN  out  1  register-file write strobe
- RF_Rd_EN  out  1  register-file read strobe
- RF_Address  out  WIDTH  register-file address
- RF_Wr_Data  out  WIDTH  register-file write data
- RF_Rd_Data  in  WIDTH  register-file read data, valid one cycle after RF_Rd_EN

## Operation
- Pending buffer holds op, address and data of one SPI strobe. A strobe is captured at the edge where it is sampled high.
- SPI_Wr_EN and SPI_Rd_EN both high in the same cycle: treated as a write; the read is dropped and SPI_Ovf is set.
- A strobe arriving while the buffer is full and not being granted in that cycle is dropped and sets SPI_Ovf. SPI_Ovf clears only on reset.
- FSM states:
  - IDLE
  - ISSUE: one RF strobe cycle
  - RD_WAIT: capture RF_Rd_Data
  - RESP: pulse SPI_Rd_Valid or H_Ack
- IDLE arbitration:
  - Pending SPI wins unless starve_cnt == STARVE_MAX and H_Req is high; then host wins.
  - Otherwise, host wins if H_Req is high.
  - No requester: stay in IDLE.
- starve_cnt:
  - Increments on each SPI grant while H_Req is high.
  - Clears on a host grant or whenever H_Req is low.
  - Saturates at STARVE_MAX.
- Write flow: ISSUE drives RF_Wr_EN, RF_Address and RF_Wr_Data for one cycle, then IDLE. A host write pulses H_Ack in the ISSUE cycle. SPI writes give no response.
- Read flow: ISSUE drives RF_Rd_EN, then RD_WAIT, then RESP (registered data output), then IDLE.
- The pending buffer frees at the ISSUE edge, so a new SPI strobe can be captured in the same cycle.
- RF_* strobes are low in every state except ISSUE. RF_Address and RF_Wr_Data hold their last value.
- Reset mid-access: all state is cleared and pending is discarded. No response is emitted for the aborted access.

## Timing
- Reset values:
  - All strobes, SPI_Rd_Valid, H_Ack and SPI_Ovf: 0.
  - SPI_Rd_Data, H_Rd_Data, RF_Address and RF_Wr_Data: 0.
  - FSM in IDLE, starve_cnt 0.
- SPI read, arbiter idle: strobe sampled at edge t, RF_Rd_EN high after t+1, SPI_Rd_Valid high after t+3 for one cycle.
- SPI write, arbiter idle: RF_Wr_EN high after t+1.
- Host read: H_Req sampled at edge t (IDLE), H_Ack high after t+3. Host write: H_Ack high after t+1.
- Throughput:
  - Back-to-back writes: one every 2 cycles.
  - Reads: one every 4 cycles.
- The SPI slave issues at most one strobe per WIDTH SCLK bits. This is ≥ 4 CLK cycles, so a lone SPI requester never overflows.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, ISSUE, RD_WAIT, RESP), 2 bits.
  - Requester-select constant (SEL_SPI, SEL_HOST).
- One natural sub-module, spi_pending_buf: capture/overflow logic and the one-deep buffer. The FSM, starvation counter and response muxing stay in the top.

## Test plan
- After reset, SPI write addr 0x05 data 0xA5 -> RF_Wr_EN pulse one cycle after strobe with addr 0x05 / data 0xA5; no SPI_Rd_Valid.
- SPI read addr 0x05, RF returns 0xA5 -> SPI_Rd_Valid pulse 3 edges after strobe, SPI_Rd_Data = 0xA5.
- H_Req and SPI strobe sampled in the same cycle -> SPI access issued first; H_Ack follows once the SPI access completes.
- H_Req held while SPI strobes keep pending full -> after 4 SPI grants the host is granted; starve_cnt returns to 0.
- Two SPI strobes in consecutive cycles while a host read is in RD_WAIT -> the first is buffered, the second is dropped, SPI_Ovf = 1 and stays 1.
- RST asserted during RD_WAIT of a host read -> no H_Ack; all outputs 0 immediately; the next request is served normally.
